threshold_detector: RTL and testbench

THRESHOLD_DETECTOR -- requirements
Module: threshold_detector

---
 rtl/threshold_detector_pkg.sv | 33 +++
 rtl/threshold_detector_popcount.sv | 18 +
 rtl/threshold_detector.sv | 170 +++++++++++++++++
 tb/tb_threshold_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_detector_pkg.sv
// Shared definitions for the threshold detector: mode encodings, the
// debounce FSM state type and the raw-match rule.
package threshold_detector_pkg;

   localparam logic [1:0] MODE_AT_LEAST = 2'b00;
   localparam logic [1:0] MODE_EXACTLY  = 2'b01;
   localparam logic [1:0] MODE_AT_MOST  = 2'b10;
   localparam logic [1:0] MODE_MAJORITY = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ARMING    = 2'b01,
      ST_ACTIVE    = 2'b10,
      ST_DISARMING = 2'b11
   } state_t;

   // Operands are widened to 32 bits so a threshold above the sample width
   // compares naturally (at-least never matches, at-most always matches).
   function automatic logic f_raw_match(input int unsigned i_count,
                                        input int unsigned i_thresh,
                                        input logic [1:0]  i_mode,
                                        input int unsigned i_n);
      logic r_m;
      unique case (i_mode)
         MODE_AT_LEAST: r_m = (i_count >= i_thresh);
         MODE_EXACTLY:  r_m = (i_count == i_thresh);
         MODE_AT_MOST:  r_m = (i_count <= i_thresh);
         default:       r_m = ((2 * i_count) > i_n);
      endcase
      return r_m;
   endfunction

endpackage

// File: rtl/threshold_detector_popcount.sv
// Purely combinational population count.
// Ports: i_data [N-1:0] sample bits, o_count [CW-1:0] number of ones.
module threshold_detector_popcount #(
   parameter  int N  = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  i_data,
   output logic [CW-1:0] o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < N; i++) begin
         o_count = o_count + CW'(i_data[i]);
      end
   end

endmodule

// File: rtl/threshold_detector.sv
// Threshold detector: counts ones in each accepted sample, compares the
// count against a threshold according to mode, registers the result behind
// a valid/ready handshake and debounces the match into a detect level with
// a saturating count of detect rising edges.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   clear                sync clear of debounce state and event_cnt
//   in_val/in_rdy        sample handshake; in_data, thresh, mode ride with it
//   out_val/out_rdy      result handshake; out_count, out_match ride with it
//   detect               debounced match level
//   event_cnt            saturating count of detect 0->1 transitions
//
// Debounce FSM
//   state        | meaning
//   ST_IDLE      | detect=0, no pending matches
//   ST_ARMING    | detect=0, run = consecutive matches seen so far
//   ST_ACTIVE    | detect=1, no pending non-matches
//   ST_DISARMING | detect=1, run = consecutive non-matches seen so far
module threshold_detector
   import threshold_detector_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int HOLD = 3,
   parameter  int ECW  = 16,
   localparam int CW   = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           in_val,
   output logic           in_rdy,
   input  logic [N-1:0]   in_data,
   input  logic [CW-1:0]  thresh,
   input  logic [1:0]     mode,
   output logic           out_val,
   input  logic           out_rdy,
   output logic [CW-1:0]  out_count,
   output logic           out_match,
   output logic           detect,
   output logic [ECW-1:0] event_cnt
);

   localparam logic [3:0] HOLD_L = 4'(HOLD);

   logic            r_out_val;
   logic [CW-1:0]   r_out_count;
   logic            r_out_match;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_run;
   logic [3:0]      w_run_nxt;
   logic [3:0]      w_run_inc;
   logic [ECW-1:0]  r_event_cnt;
   logic            w_accept;
   logic [CW-1:0]   w_count;
   logic            w_match;
   logic            w_detect;
   logic            w_detect_nxt;

   threshold_detector_popcount #(.N(N)) u_popcount (
      .i_data  (in_data),
      .o_count (w_count)
   );

   assign w_match  = f_raw_match(32'(w_count), 32'(thresh), mode, N);
   assign in_rdy   = !r_out_val || out_rdy;
   assign w_accept = in_val && in_rdy;
   assign w_run_inc = r_run + 4'd1;

   // Result register: a new accept wins over a drain, giving full throughput.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_val   <= 1'b0;
         r_out_count <= '0;
         r_out_match <= 1'b0;
      end else if (w_accept) begin
         r_out_val   <= 1'b1;
         r_out_count <= w_count;
         r_out_match <= w_match;
      end else if (out_rdy) begin
         r_out_val   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_run       <= '0;
         r_event_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         if (clear) begin
            r_event_cnt <= '0;
         end else if (w_detect_nxt && !w_detect && (r_event_cnt != '1)) begin
            r_event_cnt <= r_event_cnt + ECW'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (w_accept) begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_match) begin
                  if (HOLD_L == 4'd1) begin
                     w_state_nxt = ST_ACTIVE;
                     w_run_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_ARMING;
                     w_run_nxt   = 4'd1;
                  end
               end
            end
            ST_ARMING: begin
               if (!w_match) begin
                  w_state_nxt = ST_IDLE;
                  w_run_nxt   = '0;
               end else if (w_run_inc == HOLD_L) begin
                  w_state_nxt = ST_ACTIVE;
                  w_run_nxt   = '0;
               end else begin
                  w_run_nxt   = w_run_inc;
               end
            end
            ST_ACTIVE: begin
               if (!w_match) begin
                  if (HOLD_L == 4'd1) begin
                     w_state_nxt = ST_IDLE;
                     w_run_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_DISARMING;
                     w_run_nxt   = 4'd1;
                  end
               end
            end
            ST_DISARMING: begin
               if (w_match) begin
                  w_state_nxt = ST_ACTIVE;
                  w_run_nxt   = '0;
               end else if (w_run_inc == HOLD_L) begin
                  w_state_nxt = ST_IDLE;
                  w_run_nxt   = '0;
               end else begin
                  w_run_nxt   = w_run_inc;
               end
            end
         endcase
      end
      // clear overrides whatever the accepted sample would have done
      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_run_nxt   = '0;
      end
   end

   always_comb begin
      w_detect     = (r_state == ST_ACTIVE) || (r_state == ST_DISARMING);
      w_detect_nxt = (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_DISARMING);
   end

   assign out_val   = r_out_val;
   assign out_count = r_out_count;
   assign out_match = r_out_match;
   assign detect    = w_detect;
   assign event_cnt = r_event_cnt;

endmodule

// File: tb/tb_threshold_detector.sv
module tb_threshold_detector;

   localparam int N    = 8;
   localparam int HOLD = 3;
   localparam int ECW  = 4;
   localparam int CW   = 4;
   localparam int EVT_MAX = (1 << ECW) - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clear;
   logic           in_val;
   logic           in_rdy;
   logic [N-1:0]   in_data;
   logic [CW-1:0]  thresh;
   logic [1:0]     mode;
   logic           out_val;
   logic           out_rdy;
   logic [CW-1:0]  out_count;
   logic           out_match;
   logic           detect;
   logic [ECW-1:0] event_cnt;

   threshold_detector #(.N(N), .HOLD(HOLD), .ECW(ECW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .thresh    (thresh),
      .mode      (mode),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_count (out_count),
      .out_match (out_match),
      .detect    (detect),
      .event_cnt (event_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: result register plus a "disagreement streak" view of
   // debouncing -- detect flips once HOLD consecutive accepted samples
   // disagree with it.
   bit m_val;
   int m_count;
   bit m_match;
   bit m_detect;
   int m_streak;
   int m_evt;

   typedef struct {
      logic [7:0] d;
      int         t;
      int         m;
      int         e_cnt;
      bit         e_match;
      bit         e_det;
      int         e_evt;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int f_pop(input logic [N-1:0] d);
      int c = 0;
      for (int i = 0; i < N; i++) if (d[i]) c++;
      return c;
   endfunction

   function automatic bit f_match(input int c, input int t, input int m);
      case (m)
         0:       return c >= t;
         1:       return c == t;
         2:       return c <= t;
         default: return (2 * c) > N;
      endcase
   endfunction

   task automatic model_reset();
      m_val = 0; m_count = 0; m_match = 0;
      m_detect = 0; m_streak = 0; m_evt = 0;
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input int t, input int m,
                      input bit rdy, input bit clr);
      bit acc;
      int c;
      bit mt;
      @(negedge clk);
      in_val  = v;
      in_data = d;
      thresh  = 4'(t);
      mode    = 2'(m);
      out_rdy = rdy;
      clear   = clr;
      #1;
      chk("in_rdy", in_rdy, 32'(!m_val || rdy));
      acc = v && (!m_val || rdy);
      c   = f_pop(d);
      mt  = f_match(c, t, m);
      if (acc) begin
         m_val = 1; m_count = c; m_match = mt;
      end else if (rdy) begin
         m_val = 0;
      end
      if (clr) begin
         m_detect = 0; m_streak = 0; m_evt = 0;
      end else if (acc) begin
         if (mt != m_detect) begin
            m_streak++;
            if (m_streak == HOLD) begin
               m_detect = !m_detect;
               m_streak = 0;
               if (m_detect && m_evt < EVT_MAX) m_evt++;
            end
         end else begin
            m_streak = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_val", out_val, 32'(m_val));
      chk("out_count", out_count, m_count);
      chk("out_match", out_match, 32'(m_match));
      chk("detect", detect, 32'(m_detect));
      chk("event_cnt", event_cnt, m_evt);
   endtask

   initial begin
      tbl[0]  = '{8'h0F, 0, 3, 4, 0, 0, 0};
      tbl[1]  = '{8'h1F, 0, 3, 5, 1, 0, 0};
      tbl[2]  = '{8'h1F, 0, 3, 5, 1, 0, 0};
      tbl[3]  = '{8'h1F, 0, 3, 5, 1, 1, 1};
      tbl[4]  = '{8'h01, 4, 0, 1, 0, 1, 1};
      tbl[5]  = '{8'h03, 4, 0, 2, 0, 1, 1};
      tbl[6]  = '{8'hFF, 4, 0, 8, 1, 1, 1};
      tbl[7]  = '{8'h00, 4, 0, 0, 0, 1, 1};
      tbl[8]  = '{8'h80, 4, 0, 1, 0, 1, 1};
      tbl[9]  = '{8'h00, 4, 0, 0, 0, 0, 1};
      tbl[10] = '{8'hFF, 9, 0, 8, 0, 0, 1};
      tbl[11] = '{8'hFF, 15, 2, 8, 1, 0, 1};
      tbl[12] = '{8'hFF, 8, 1, 8, 1, 0, 1};
      tbl[13] = '{8'h00, 0, 2, 0, 1, 1, 2};

      // Reset with a valid sample presented: nothing may be accepted.
      rst_n = 1'b0; clear = 1'b0; in_val = 1'b1; in_data = 8'hFF;
      thresh = '0; mode = 2'd0; out_rdy = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_out_val", out_val, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_match", out_match, 0);
      chk("rst_detect", detect, 0);
      chk("rst_event_cnt", event_cnt, 0);
      chk("rst_in_rdy", in_rdy, 1);
      in_val = 1'b0;
      rst_n  = 1'b1;

      // Table vectors, back-to-back with out_rdy=1.
      for (int i = 0; i < 14; i++) begin
         cyc(1, tbl[i].d, tbl[i].t, tbl[i].m, 1, 0);
         chk($sformatf("tbl%0d_val", i), out_val, 1);
         chk($sformatf("tbl%0d_count", i), out_count, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_match", i), out_match, 32'(tbl[i].e_match));
         chk($sformatf("tbl%0d_detect", i), detect, 32'(tbl[i].e_det));
         chk($sformatf("tbl%0d_evt", i), event_cnt, tbl[i].e_evt);
      end

      // Back-pressure: result holds while out_rdy=0, next accept on drain edge.
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(1, 8'h07, 3, 1, 0, 0);
      chk("bp_acc_val", out_val, 1);
      chk("bp_acc_count", out_count, 3);
      chk("bp_acc_match", out_match, 1);
      chk("bp_acc_rdy", in_rdy, 0);
      for (int k = 0; k < 2; k++) begin
         cyc(1, 8'hFF, 3, 1, 0, 0);
         chk($sformatf("bp_hold%0d_count", k), out_count, 3);
         chk($sformatf("bp_hold%0d_match", k), out_match, 1);
         chk($sformatf("bp_hold%0d_rdy", k), in_rdy, 0);
      end
      cyc(1, 8'hFF, 3, 1, 1, 0);
      chk("bp_drain_val", out_val, 1);
      chk("bp_drain_count", out_count, 8);
      chk("bp_drain_match", out_match, 0);

      // clear during a matching accept in ARMING.
      cyc(0, 8'h00, 0, 0, 1, 1);
      cyc(1, 8'hFF, 0, 0, 1, 0);
      cyc(1, 8'h0F, 2, 0, 1, 1);
      chk("clr_detect", detect, 0);
      chk("clr_evt", event_cnt, 0);
      chk("clr_out_val", out_val, 1);
      chk("clr_out_count", out_count, 4);
      chk("clr_out_match", out_match, 1);
      cyc(1, 8'hFF, 0, 0, 1, 0);
      cyc(1, 8'hFF, 0, 0, 1, 0);
      chk("clr_restart_detect", detect, 0);
      cyc(1, 8'hFF, 0, 0, 1, 0);
      chk("clr_rearm_detect", detect, 1);
      chk("clr_rearm_evt", event_cnt, 1);

      // Event counter saturation over 16 detect cycles.
      cyc(0, 8'h00, 0, 0, 1, 1);
      for (int k = 0; k < 16; k++) begin
         repeat (3) cyc(1, 8'hFF, 0, 0, 1, 0);
         repeat (3) cyc(1, 8'h00, 1, 0, 1, 0);
      end
      chk("sat_evt", event_cnt, EVT_MAX);
      chk("sat_detect", detect, 0);

      // Asynchronous reset while ACTIVE with a held result.
      repeat (3) cyc(1, 8'hFF, 0, 0, 1, 0);
      cyc(1, 8'hFF, 0, 0, 0, 0);
      chk("arst_pre_detect", detect, 1);
      chk("arst_pre_val", out_val, 1);
      @(negedge clk);
      in_val = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_val", out_val, 0);
      chk("arst_detect", detect, 0);
      chk("arst_out_count", out_count, 0);
      chk("arst_evt", event_cnt, 0);
      chk("arst_in_rdy", in_rdy, 1);
      model_reset();
      @(posedge clk);
      #1;
      chk("arst_noacc_val", out_val, 0);
      @(negedge clk);
      in_val = 1'b0;
      rst_n  = 1'b1;

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
